kp_window_gen: RTL and testbench

- Parametrised successor to the fixed 3x3 line-buffer controller.
- Streams raster pixels into a rotating bank of KSIZE+1 line buffers and emits a full KSIZE x KSIZE neighbourhood window for every pixel of the frame, including border pixels.
- Adds a selectable border mode (replicate or zero), valid/ready backpressure on both sides, frame/line markers, and tail flush of the last rows without further input.
- Sits between the pixel source and the Gaussian/filter MAC stages.

---
 rtl/kp_window_gen.sv | 130 +++++++++++++
 tb/tb_kp_window_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_window_gen.sv
// kp_window_gen: streams raster pixels through KSIZE+1 rotating line buffers and emits a
// KSIZE x KSIZE neighbourhood window for every pixel, with replicate or zero borders.
module kp_window_gen #(
    parameter int LINE_LENGTH = 640,
    parameter int LINE_COUNT  = 480,
    parameter int DATA_WIDTH  = 8,
    parameter int KSIZE       = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rstn,
    input  logic                              i_border_mode,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] o_window,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_sof,
    output logic                              o_eol,
    output logic                              o_eof
);
    localparam int R  = (KSIZE - 1) / 2;
    localparam int NB = KSIZE + 1;
    localparam int BW = $clog2(NB);
    localparam int XW = $clog2(LINE_LENGTH);
    localparam int YW = $clog2(LINE_COUNT);
    localparam int CW = $clog2(LINE_COUNT + 1);

    if (KSIZE < 3 || KSIZE > 7 || KSIZE % 2 == 0) begin : g_bad_ksize
        $error("kp_window_gen: KSIZE must be odd and within 3..7");
    end

    logic [DATA_WIDTH-1:0]             mem [NB][LINE_LENGTH];
    logic [XW-1:0]                     in_x, out_x;
    logic [YW-1:0]                     in_y, out_y;
    logic [BW-1:0]                     in_buf, out_buf;
    logic [CW-1:0]                     rows_in;
    logic                              run, in_done, zero_mode;
    logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win;
    logic accept, load, row_ok, in_eol, in_last, out_eol, out_last;

    assign in_eol   = in_x == XW'(LINE_LENGTH - 1);
    assign in_last  = in_eol && in_y == YW'(LINE_COUNT - 1);
    assign out_eol  = out_x == XW'(LINE_LENGTH - 1);
    assign out_last = out_eol && out_y == YW'(LINE_COUNT - 1);
    // Row out_y+R+1 shares a buffer only with row out_y-R-1, which no later window reads.
    assign o_ready  = run && !in_done && int'(in_y) <= int'(out_y) + R + 1;
    assign accept   = i_valid && o_ready;
    assign row_ok   = int'(rows_in) > ((int'(out_y) + R < LINE_COUNT - 1) ? int'(out_y) + R : LINE_COUNT - 1);
    assign load     = row_ok && (!o_valid || i_ready);

    always_comb begin
        int sy, sx, cy, cx, b;
        sy = 0;
        sx = 0;
        cy = 0;
        cx = 0;
        b = 0;
        win = '0;
        for (int i = 0; i < KSIZE; i++) begin
            sy = int'(out_y) - R + i;
            cy = sy < 0 ? 0 : (sy > LINE_COUNT - 1 ? LINE_COUNT - 1 : sy);
            b = int'(out_buf) + cy - int'(out_y);
            b = b < 0 ? b + NB : (b >= NB ? b - NB : b);
            for (int j = 0; j < KSIZE; j++) begin
                sx = int'(out_x) - R + j;
                cx = sx < 0 ? 0 : (sx > LINE_LENGTH - 1 ? LINE_LENGTH - 1 : sx);
                win[(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH] =
                    (zero_mode && (sy != cy || sx != cx)) ? '0 : mem[BW'(b)][XW'(cx)];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept)
            mem[in_buf][in_x] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            run       <= 1'b0;
            in_done   <= 1'b0;
            zero_mode <= 1'b0;
            in_x      <= '0;
            in_y      <= '0;
            in_buf    <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_buf   <= '0;
            rows_in   <= '0;
            o_valid   <= 1'b0;
            o_sof     <= 1'b0;
            o_eol     <= 1'b0;
            o_eof     <= 1'b0;
            o_window  <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                if (in_x == '0 && in_y == '0)
                    zero_mode <= i_border_mode;
                in_x <= in_eol ? '0 : in_x + 1'b1;
                if (in_eol) begin
                    in_y   <= in_last ? '0 : in_y + 1'b1;
                    in_buf <= (in_last || in_buf == BW'(NB - 1)) ? '0 : in_buf + 1'b1;
                end
            end
            if (o_valid && i_ready && o_eof)
                in_done <= 1'b0;
            else if (accept && in_last)
                in_done <= 1'b1;
            // The last window of a frame is only loadable once all input rows are in.
            if (load && out_last)
                rows_in <= '0;
            else if (accept && in_eol)
                rows_in <= rows_in + 1'b1;
            if (load) begin
                o_window <= win;
                o_sof    <= out_x == '0 && out_y == '0;
                o_eol    <= out_eol;
                o_eof    <= out_last;
                out_x    <= out_eol ? '0 : out_x + 1'b1;
                if (out_eol) begin
                    out_y   <= out_last ? '0 : out_y + 1'b1;
                    out_buf <= (out_last || out_buf == BW'(NB - 1)) ? '0 : out_buf + 1'b1;
                end
            end
            o_valid <= load || (o_valid && !i_ready);
        end
    end
endmodule

// File: tb/tb_kp_window_gen.sv
// tb_kp_window_gen: three window generator configurations driven with directed and random
// frames; expected windows come from a direct coordinate model and are scoreboarded.
module tb_kp_window_gen;
    localparam int DW = 8;

    logic clk;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clip(input int v, input int n);
        return v < 0 ? 0 : (v >= n ? n - 1 : v);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LL = (g == 2) ? 6 : 4;
        localparam int LC = (g == 1) ? 6 : 3;
        localparam int K  = (g == 2) ? 5 : 3;
        localparam int R  = (K - 1) / 2;
        localparam int WW = K * K * DW;

        logic rstn, valid, mode, rdy, ordy, ov, sof, eol, eof;
        logic [DW-1:0] din;
        logic [WW-1:0] win;
        logic [DW-1:0] pix [$];
        logic [WW-1:0] exp_w [$];
        int exp_p [$];
        int ready_pct = 100;
        bit stall_armed = 0;
        bit done = 0;

        kp_window_gen #(
            .LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW), .KSIZE(K)
        ) dut (
            .i_clk(clk), .i_rstn(rstn), .i_border_mode(mode), .i_data(din), .i_valid(valid),
            .o_ready(ordy), .o_window(win), .o_valid(ov), .i_ready(rdy),
            .o_sof(sof), .o_eol(eol), .o_eof(eof)
        );

        task automatic fill(input bit patt);
            pix.delete();
            for (int p = 0; p < LL * LC; p++)
                pix.push_back(patt ? DW'(10 * (p / LL) + p % LL) : DW'($urandom));
        endtask

        // Expected windows straight from image coordinates: clamp or zero outside the frame.
        task automatic push_frame(input bit m);
            for (int y = 0; y < LC; y++)
                for (int x = 0; x < LL; x++) begin
                    logic [WW-1:0] w;
                    w = '0;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++) begin
                            int sy, sx;
                            sy = y - R + i;
                            sx = x - R + j;
                            if (!(m && (sy < 0 || sy >= LC || sx < 0 || sx >= LL)))
                                w[(i*K+j)*DW +: DW] = pix[clip(sy, LC) * LL + clip(sx, LL)];
                        end
                    exp_w.push_back(w);
                    exp_p.push_back(y * LL + x);
                end
        endtask

        task automatic send(input bit m, input int vpct, input int from, input int upto,
                            input int cyc, output int n);
            n = from;
            for (int c = 0; c < cyc && n < upto; c++) begin
                bit acc;
                valid = $urandom_range(99) < vpct;
                din = pix[n];
                mode = (n == 0) ? m : 1'($urandom);
                @(negedge clk);
                acc = valid && ordy;
                @(posedge clk);
                #1;
                if (acc) n++;
            end
            valid = 0;
        endtask

        task automatic wait_drain();
            int t = 0;
            while (exp_p.size() > 0 && t < 3000) begin
                @(posedge clk);
                #1;
                t++;
            end
            check($sformatf("i%0d drain", g), exp_p.size(), 0);
        endtask

        task automatic run_frame(input bit m, input int vpct, input int rpct);
            int n;
            push_frame(m);
            ready_pct = rpct;
            send(m, vpct, 0, LL * LC, 5000, n);
            check($sformatf("i%0d frame input", g), n, LL * LC);
            wait_drain();
        endtask

        task automatic do_reset();
            rstn = 0;
            valid = 0;
            @(posedge clk);
            #1;
            check($sformatf("i%0d reset outputs", g), {ordy, ov, sof, eol, eof, win}, '0);
            exp_w.delete();
            exp_p.delete();
            rstn = 1;
            @(posedge clk);
            #1;
            check($sformatf("i%0d ready after reset", g), ordy, 1);
        endtask

        task automatic start();
            rstn = 0;
            valid = 0;
            din = 0;
            mode = 0;
            @(posedge clk);
            #1;
            do_reset();
        endtask

        task automatic random_frames();
            repeat (5) begin
                fill(0);
                run_frame(1'($urandom), $urandom_range(100, 30), $urandom_range(100, 30));
            end
        endtask

        initial begin
            int stall = 0;
            rdy = 0;
            forever begin
                @(posedge clk);
                #1;
                if (stall > 0) begin
                    rdy = 0;
                    stall--;
                end else if (stall_armed && ov && exp_p.size() > 0 && exp_p[0] == LL + 2) begin
                    stall_armed = 0;
                    stall = 4;
                    rdy = 0;
                end else
                    rdy = $urandom_range(99) < ready_pct;
            end
        end

        initial begin
            bit held;
            logic [WW+2:0] hold_v;
            held = 0;
            hold_v = '0;
            forever begin
                @(negedge clk);
                if (!rstn)
                    held = 0;
                else begin
                    if (held)
                        check($sformatf("i%0d hold", g), {ov, eof, eol, sof, win}, {1'b1, hold_v});
                    if (ov && rdy) begin
                        if (exp_p.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL i%0d extra window: got %0h expected none", g, win);
                        end else begin
                            int p;
                            logic [WW-1:0] w;
                            p = exp_p.pop_front();
                            w = exp_w.pop_front();
                            check($sformatf("i%0d window x=%0d y=%0d", g, p % LL, p / LL), win, w);
                            check($sformatf("i%0d markers x=%0d y=%0d", g, p % LL, p / LL),
                                  {sof, eol, eof}, {p == 0, p % LL == LL - 1, p == LL * LC - 1});
                        end
                    end
                    held = ov && !rdy;
                    hold_v = {eof, eol, sof, win};
                end
            end
        end

        if (g == 0) begin : g_dir
            initial begin
                int n;
                start();
                fill(1);
                run_frame(0, 100, 100);
                fill(1);
                run_frame(1, 100, 100);
                fill(1);
                stall_armed = 1;
                run_frame(0, 100, 100);
                check("i0 stall seen", stall_armed, 0);
                fill(0);
                push_frame(1);
                send(1, 100, 0, 7, 500, n);
                check("i0 pixels before reset", n, 7);
                do_reset();
                fill(1);
                run_frame(0, 80, 100);
                random_frames();
                done = 1;
            end
        end else if (g == 1) begin : g_dir
            initial begin
                int n;
                start();
                fill(1);
                push_frame(0);
                ready_pct = 0;
                send(0, 100, 0, LL * LC, 40, n);
                check("i1 throttle accepted", n, 12);
                check("i1 throttle o_ready", ordy, 0);
                ready_pct = 100;
                send(0, 100, n, LL * LC, 2000, n);
                check("i1 throttle frame input", n, LL * LC);
                wait_drain();
                random_frames();
                done = 1;
            end
        end else begin : g_dir
            initial begin
                start();
                fill(1);
                run_frame(0, 100, 100);
                fill(1);
                run_frame(1, 100, 60);
                random_frames();
                done = 1;
            end
        end
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        int t = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && t < 80000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 80000) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d cycles expected completion", t);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
